param_clk_div: RTL and testbench
================================

// Module: param_clk_div
// PURPOSE
//  Parametrised integer clock divider; next generation of the single-ratio divider in the clock/reset subsystem.
//  Divides I_ref_clk by a runtime ratio of DIV_W bits. Ratio and enable changes take effect only at
//  period boundaries, so the output never glitches. Adds a pulse/duty mode select, a period-start tick
//  and readback of the active ratio. Feeds the UART/peripheral clock trees.
// PARAMETERS
//  DIV_W      8   width of ratio bus and internal counter; max ratio 2^DIV_W-1
//  RST_MODE   0   reset value of internal mode register (0 = duty, 1 = pulse)
// PORTS
//  I_ref_clk        in   1      reference clock; the only clock
//  I_rst_n          in   1      asynchronous reset, active low
//  I_clk_en         in   1      divider enable; sampled at period boundary only
//  I_div_ratio      in   DIV_W  requested ratio; 0/1 = bypass; sampled at period boundary only
//  I_mode           in   1      0 = duty output, 1 = pulse output; sampled at period boundary only
//  o_div_clk        out  1      divided clock, or I_ref_clk when in bypass
//  o_div_tick       out  1      registered strobe, high for the ref cycle in which a divided period starts
//  o_ratio_active   out  DIV_W  ratio currently in use; 0 while in bypass
// BEHAVIOUR
//  State regs: run, cnt[DIV_W], ratio_q[DIV_W], mode_q, div_clk_q, tick_q.
//  Reset (async, I_rst_n=0): run=0, cnt=0, ratio_q=0, mode_q=RST_MODE, div_clk_q=0, tick_q=0.
//   o_div_clk = I_ref_clk, o_div_tick = 0, o_ratio_active = 0. Reset mid-period aborts at once.
//  boundary = !run || (cnt == ratio_q-1). Evaluated every I_ref_clk rising edge.
//  At boundary: go = I_clk_en && (I_div_ratio >= 2).
//   - go=1: run<=1, cnt<=0, ratio_q<=I_div_ratio, mode_q<=I_mode, div_clk_q<=1, tick_q<=1.
//   - go=0: run<=0, cnt<=0, ratio_q<=0, div_clk_q<=0, tick_q<=0.
//  Not at boundary: cnt<=cnt+1; tick_q<=0; I_div_ratio/I_clk_en/I_mode ignored.
//   - duty mode (mode_q=0): div_clk_q <= (cnt+1 < ratio_q>>1). High floor(R/2), low ceil(R/2) cycles.
//   - pulse mode (mode_q=1): div_clk_q <= 0. High exactly 1 ref cycle per period.
//  Output mux: o_div_clk = run ? div_clk_q : I_ref_clk. Only switches on a rising ref edge: ref and
//   div_clk_q both high on entry; on exit div_clk_q is low and the ref edge is rising. No runt pulses.
//  Period = ratio_q ref cycles exactly. First divided rising edge = the ref edge that samples go=1.
//  Latency: a new ratio applies at the first boundary after it is presented. Worst case:
//   old ratio_q cycles.
//  o_div_tick = tick_q. o_ratio_active = ratio_q.
//  Arithmetic: cnt and comparisons are DIV_W bits unsigned. cnt+1 is evaluated at DIV_W+1 bits
//   (no wrap). ratio_q-1 never underflows, since ratio_q >= 2 whenever run=1.
//  Simultaneous: enable drop and ratio change in the same cycle mid-period are both deferred to the
//   boundary. Ratio changed back before the boundary: the value present at the boundary wins.
//  Max ratio 2^DIV_W-1 (255 at default): cnt counts 0..254 and never wraps.
// CONFIGURATION
//  CLK_DIV_ODD_DUTY_EN defined:
//   - Adds a falling-edge flop neg_q <= div_clk_q (same clock, falling edge, same async reset to 0).
//   - Duty mode with odd ratio_q and run=1: o_div_clk = div_clk_q | neg_q. High time becomes R/2
//     ref cycles (exact 50%).
//   - Even ratios and pulse mode: output unchanged. Bypass: output unchanged.
//  Not defined: no falling-edge logic. Odd ratios give floor(R/2) high time, as described above.
// TESTING
//  T1 reset: assert I_rst_n=0 mid-period at ratio 6 -> o_div_clk tracks I_ref_clk, tick=0, ratio_active=0.
//  T2 even/odd duty: en=1, ratio=4 -> period 4, high 2. ratio=5 -> period 5, high 2;
//     with CLK_DIV_ODD_DUTY_EN high 2.5. Tick once per period.
//  T3 bypass: ratio=0 or 1, or en=0 -> o_div_clk==I_ref_clk, ratio_active=0, no tick.
//     ratio=2 -> period 2, high 1.
//  T4 mid-period change: running at 8, set ratio=3 at cnt=2 -> current period stays 8 cycles,
//     next periods are 3. No glitch (check minimum pulse width >= 1 ref cycle).
//  T5 pulse mode: I_mode=1, ratio=7 -> o_div_clk high 1 of every 7 cycles. Mode change is applied
//     only at boundary.
//  T6 max/enable drop: ratio=255 -> cnt reaches 254 then 0, no wrap. Drop en at cnt=100 ->
//     bypass starts at the next boundary on a rising ref edge.

Source files
------------

// File: rtl/param_clk_div.sv
// param_clk_div: runtime-ratio integer clock divider with glitch-free bypass,
// duty/pulse output modes, a period-start tick and readback of the active ratio.
//
// Parameters
//   DIV_W     width of the ratio bus and period counter (max ratio 2^DIV_W-1)
//   RST_MODE  reset value of the latched mode (0 = duty, 1 = pulse)
//
// Ports
//   I_ref_clk       in   1      reference clock, the only clock
//   I_rst_n         in   1      asynchronous reset, active low
//   I_clk_en        in   1      divider enable, sampled at period boundaries
//   I_div_ratio     in   DIV_W  requested ratio, 0/1 = bypass, sampled at boundaries
//   I_mode          in   1      0 = duty output, 1 = pulse output, sampled at boundaries
//   o_div_clk       out  1      divided clock, or I_ref_clk while in bypass
//   o_div_tick      out  1      high for the ref cycle in which a divided period starts
//   o_ratio_active  out  DIV_W  ratio in use, 0 while in bypass
//
// Build option
//   CLK_DIV_ODD_DUTY_EN  adds a falling-edge stage that stretches the high phase
//                        of odd duty-mode ratios by half a ref cycle (exact 50%).
module param_clk_div #(
   parameter int DIV_W    = 8,
   parameter bit RST_MODE = 1'b0
) (
   input  logic             I_ref_clk,
   input  logic             I_rst_n,
   input  logic             I_clk_en,
   input  logic [DIV_W-1:0] I_div_ratio,
   input  logic             I_mode,
   output logic             o_div_clk,
   output logic             o_div_tick,
   output logic [DIV_W-1:0] o_ratio_active
);
   logic             run, mode_q, div_clk_q, tick_q;
   logic [DIV_W-1:0] cnt, ratio_q;
   logic [DIV_W:0]   cnt_inc;
   logic             boundary, go, duty_next, stretch;

   // cnt+1 is one bit wider so the duty compare can never wrap at max ratio.
   always_comb begin
      cnt_inc   = {1'b0, cnt} + (DIV_W+1)'(1);
      boundary  = !run || (cnt == ratio_q - DIV_W'(1));
      go        = I_clk_en && (I_div_ratio >= DIV_W'(2));
      duty_next = cnt_inc < {1'b0, ratio_q >> 1};
   end

   // All input sampling happens only at a boundary, so a period is never cut short.
   always_ff @(posedge I_ref_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         run       <= 1'b0;
         cnt       <= '0;
         ratio_q   <= '0;
         mode_q    <= RST_MODE;
         div_clk_q <= 1'b0;
         tick_q    <= 1'b0;
      end else if (boundary) begin
         run       <= go;
         cnt       <= '0;
         ratio_q   <= go ? I_div_ratio : '0;
         mode_q    <= go ? I_mode : mode_q;
         div_clk_q <= go;
         tick_q    <= go;
      end else begin
         cnt       <= cnt_inc[DIV_W-1:0];
         tick_q    <= 1'b0;
         div_clk_q <= !mode_q && duty_next;
      end
   end

`ifdef CLK_DIV_ODD_DUTY_EN
   // Half-cycle delayed copy; OR-ing it in extends the high phase by half a ref cycle.
   logic neg_q;
   always_ff @(negedge I_ref_clk or negedge I_rst_n) begin
      if (!I_rst_n) neg_q <= 1'b0;
      else          neg_q <= div_clk_q;
   end
   assign stretch = !mode_q && ratio_q[0] && neg_q;
`else
   assign stretch = 1'b0;
`endif

   // The mux only flips on a rising ref edge: entering run both sides are high,
   // leaving run div_clk_q is already low while ref rises.
   assign o_div_clk      = run ? (div_clk_q | stretch) : I_ref_clk;
   assign o_div_tick     = tick_q;
   assign o_ratio_active = ratio_q;
endmodule

// File: tb/tb_param_clk_div.sv
// tb_param_clk_div: self-checking bench for param_clk_div (phase-based model plus directed checks).
module tb_param_clk_div;
   localparam int DIV_W = 8;
`ifdef CLK_DIV_ODD_DUTY_EN
   localparam bit ODD = 1'b1;
`else
   localparam bit ODD = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst_n, en, mode;
   logic [DIV_W-1:0] ratio;
   logic             div_clk, tick;
   logic [DIV_W-1:0] ratio_act;
   int               tests = 0, fails = 0;

   param_clk_div #(.DIV_W(DIV_W), .RST_MODE(1'b0)) dut (
      .I_ref_clk(clk), .I_rst_n(rst_n), .I_clk_en(en), .I_div_ratio(ratio), .I_mode(mode),
      .o_div_clk(div_clk), .o_div_tick(tick), .o_ratio_active(ratio_act)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: which phase of which period we are in; outputs follow from phase arithmetic.
   logic m_run, m_mode;
   int   m_ph, m_r;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_run <= 1'b0;
         m_ph  <= 0;
         m_r   <= 0;
         m_mode <= 1'b0;
      end else if (!m_run || m_ph == m_r - 1) begin
         if (en && ratio >= 2) begin
            m_run <= 1'b1; m_ph <= 0; m_r <= int'(ratio); m_mode <= mode;
         end else begin
            m_run <= 1'b0; m_ph <= 0; m_r <= 0;
         end
      end else m_ph <= m_ph + 1;
   end

   // Compare 1 time unit into every half ref cycle.
   always begin
      logic exp_clk;
      @(posedge clk or negedge clk);
      #1;
      if (!m_run) exp_clk = clk;
      else if (m_mode) exp_clk = (m_ph == 0);
      else exp_clk = (m_ph < m_r / 2) || (ODD && clk && (m_r % 2 == 1) && (m_ph == m_r / 2));
      chk("model_clk", div_clk, exp_clk);
      chk("model_tick", tick, m_run && m_ph == 0);
      chk("model_ratio", ratio_act, m_r);
   end

   task automatic wait_tick(output int n);
      n = 0;
      for (int i = 0; i < 600; i++) begin
         @(posedge clk); #2;
         n++;
         if (tick) return;
      end
      chk("tick_timeout", 0, 1);
   endtask

   // Starting from the next tick, returns period length and number of high half-cycles.
   task automatic measure(output int p, output int h);
      int n;
      wait_tick(n);
      p = 0; h = 0;
      for (int i = 0; i < 600; i++) begin
         h += int'(div_clk);
         @(negedge clk); #2;
         h += int'(div_clk);
         @(posedge clk); #2;
         p++;
         if (tick) return;
      end
      chk("period_timeout", 0, 1);
   endtask

   task automatic bypass_check(input string name);
      int t;
      repeat (6) @(posedge clk);
      #2;
      t = 0;
      for (int i = 0; i < 10; i++) begin
         t += int'(tick);
         @(posedge clk); #2;
      end
      chk({name, "_ticks"}, t, 0);
      chk({name, "_ratio"}, ratio_act, 0);
      chk({name, "_clk_hi"}, div_clk, 1);
   endtask

   initial begin
      int p, h, n;
      rst_n = 1'b0; en = 1'b0; ratio = '0; mode = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_clk_lo", div_clk, 0);
      chk("rst_tick", tick, 0);
      chk("rst_ratio", ratio_act, 0);
      @(posedge clk); #1;
      chk("rst_clk_hi", div_clk, 1);
      @(negedge clk) rst_n = 1'b1;
      // even / odd duty
      @(posedge clk); #2;
      en = 1'b1; ratio = 8'd4;
      measure(p, h);
      chk("r4_period", p, 4);
      chk("r4_high_halves", h, 4);
      chk("r4_active", ratio_act, 4);
      ratio = 8'd5;
      measure(p, h);
      chk("r5_period", p, 5);
      chk("r5_high_halves", h, ODD ? 5 : 4);
      // ratio 2 and bypass cases
      ratio = 8'd2;
      measure(p, h);
      chk("r2_period", p, 2);
      chk("r2_high_halves", h, 2);
      ratio = 8'd0;
      bypass_check("byp_r0");
      ratio = 8'd1;
      bypass_check("byp_r1");
      en = 1'b0; ratio = 8'd5;
      bypass_check("byp_en0");
      // mid-period ratio change
      en = 1'b1; ratio = 8'd8;
      measure(p, h);
      chk("r8_period", p, 8);
      chk("r8_high_halves", h, 8);
      repeat (2) @(posedge clk);
      #2;
      ratio = 8'd3;
      wait_tick(n);
      chk("r8_kept_after_change", n, 6);
      measure(p, h);
      chk("r3_period", p, 3);
      chk("r3_high_halves", h, ODD ? 3 : 2);
      // pulse mode and deferred mode change
      mode = 1'b1; ratio = 8'd7;
      measure(p, h);
      chk("p7_period", p, 7);
      chk("p7_high_halves", h, 2);
      repeat (2) @(posedge clk);
      #2;
      mode = 1'b0;
      wait_tick(n);
      chk("p7_kept_after_mode", n, 5);
      measure(p, h);
      chk("d7_period", p, 7);
      chk("d7_high_halves", h, ODD ? 7 : 6);
      // reset mid-period at ratio 6
      ratio = 8'd6;
      measure(p, h);
      chk("r6_period", p, 6);
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_clk_hi", div_clk, 1);
      chk("midrst_tick", tick, 0);
      chk("midrst_ratio", ratio_act, 0);
      @(negedge clk); #1;
      chk("midrst_clk_lo", div_clk, 0);
      rst_n = 1'b1;
      // max ratio and enable drop mid-period
      ratio = 8'd255;
      measure(p, h);
      chk("r255_period", p, 255);
      chk("r255_high_halves", h, ODD ? 255 : 254);
      repeat (100) @(posedge clk);
      #2;
      en = 1'b0;
      n = 0;
      for (int i = 0; i < 300; i++) begin
         @(posedge clk); #2;
         n++;
         if (ratio_act == 0) break;
      end
      chk("en_drop_latency", n, 155);
      chk("en_drop_clk_hi", div_clk, 1);
      @(negedge clk); #2;
      chk("en_drop_clk_lo", div_clk, 0);
      repeat (3) @(posedge clk);
      #2;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
